ysyx_22040632_rr_arbiter: RTL and testbench

N-master, one-slave memory-request arbiter: the parametrised successor to the two-port icache/dcache arbiter in front of the AXI read/write bridge. Supports any master count, a fixed-priority or round-robin mode, multi-beat read bursts with per-burst grant locking, and a sticky protocol-error flag. Sits between the L1 caches, plus optional extra masters such as a DMA or page-table walker, and `ysyx_22040632_rw`.

---
 rtl/ysyx_22040632_riscv_pkg.sv | 12 +
 rtl/ysyx_22040632_rr_pick.sv | 36 +++
 rtl/ysyx_22040632_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_ysyx_22040632_rr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040632_riscv_pkg.sv
// Shared core-side definitions: memory arbiter FSM encoding and master-count limit.
package ysyx_22040632_riscv_pkg;

    localparam int ARB_MAX_M = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ysyx_22040632_rr_pick.sv
// Combinational rotate-priority picker: first requester at or after ptr, wrapping.
// With rr_en=0 the search always starts at index 0 (fixed priority).
module ysyx_22040632_rr_pick #(
    parameter int NUM_M = 2,
    parameter int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_en,
    output logic [NUM_M-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    int base;
    int j;

    // Walk offsets from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        base = rr_en ? int'(ptr) : 0;
        j    = 0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            j = base + i;
            if (j >= NUM_M) begin
                j = j - NUM_M;
            end
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/ysyx_22040632_rr_arbiter.sv
// N-master to one-slave request arbiter with per-burst grant lock and sticky protocol error.
// Request fields are captured at grant; responses pass through combinationally to the owner.
module ysyx_22040632_rr_arbiter
    import ysyx_22040632_riscv_pkg::*;
#(
    parameter  int NUM_M  = 2,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 64,
    parameter  int LEN_W  = 8,
    parameter  int RR_EN  = 1,
    localparam int IDX_W  = $clog2(NUM_M)
) (
    input  logic                        clk,
    input  logic                        rrst_n,
    input  logic [NUM_M-1:0]            m_req_valid,
    output logic [NUM_M-1:0]            m_req_ready,
    input  logic [NUM_M*ADDR_W-1:0]     m_req_addr,
    input  logic [NUM_M-1:0]            m_req_wen,
    input  logic [NUM_M*DATA_W-1:0]     m_req_wdata,
    input  logic [NUM_M*DATA_W/8-1:0]   m_req_wstrb,
    input  logic [NUM_M*LEN_W-1:0]      m_req_len,
    output logic [NUM_M-1:0]            m_rsp_valid,
    output logic [DATA_W-1:0]           m_rsp_data,
    output logic                        m_rsp_last,
    output logic                        s_req_valid,
    input  logic                        s_req_ready,
    output logic [ADDR_W-1:0]           s_req_addr,
    output logic                        s_req_wen,
    output logic [DATA_W-1:0]           s_req_wdata,
    output logic [DATA_W/8-1:0]         s_req_wstrb,
    output logic [LEN_W-1:0]            s_req_len,
    input  logic                        s_rsp_valid,
    input  logic [DATA_W-1:0]           s_rsp_data,
    input  logic                        s_rsp_last,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        busy,
    output logic                        proto_err
);

    localparam logic [NUM_M-1:0] ONE = {{(NUM_M-1){1'b0}}, 1'b1};

    arb_state_e            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_M-1:0]      pick_gnt;
    logic [LEN_W-1:0]      beat_cnt;
    logic [LEN_W-1:0]      len_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wen_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;

    ysyx_22040632_rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (m_req_valid),
        .ptr   (rr_ptr),
        .rr_en (RR_EN != 0),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pick_gnt) begin
                        grant_id <= pick_idx;
                        addr_q   <= m_req_addr[pick_idx*ADDR_W +: ADDR_W];
                        wen_q    <= m_req_wen[pick_idx];
                        wdata_q  <= m_req_wdata[pick_idx*DATA_W +: DATA_W];
                        wstrb_q  <= m_req_wstrb[pick_idx*(DATA_W/8) +: DATA_W/8];
                        // Writes are always a single response beat.
                        len_q    <= m_req_wen[pick_idx] ? '0 : m_req_len[pick_idx*LEN_W +: LEN_W];
                        beat_cnt <= m_req_wen[pick_idx] ? '0 : m_req_len[pick_idx*LEN_W +: LEN_W];
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (s_req_ready) begin
                        beat_cnt <= len_q;
                        state    <= RSP;
                    end
                end
                RSP: begin
                    if (s_rsp_valid) begin
                        if (beat_cnt != '0) begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end
                        if (s_rsp_last != (beat_cnt == '0)) begin
                            proto_err <= 1'b1;
                        end
                        if (s_rsp_last) begin
                            state <= IDLE;
                            if (RR_EN != 0) begin
                                rr_ptr <= (grant_id == IDX_W'(NUM_M - 1)) ? '0 : grant_id + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_req_valid = (state == REQ);
    assign s_req_addr  = addr_q;
    assign s_req_wen   = wen_q;
    assign s_req_wdata = wdata_q;
    assign s_req_wstrb = wstrb_q;
    assign s_req_len   = len_q;

    assign m_req_ready = (state == REQ && s_req_ready) ? (ONE << grant_id) : '0;
    assign m_rsp_valid = (state == RSP && s_rsp_valid) ? (ONE << grant_id) : '0;
    assign m_rsp_data  = (state == RSP) ? s_rsp_data : '0;
    assign m_rsp_last  = (state == RSP) & s_rsp_last;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ysyx_22040632_rr_arbiter.sv
// Two 4-master arbiters (round-robin and fixed priority) driven in lock-step by one slave model.
module tb_ysyx_22040632_rr_arbiter;

    localparam int NM = 4;

    logic clk = 1'b0;
    logic rrst_n;
    always #5 clk = ~clk;

    logic [NM-1:0] req_valid;
    logic [NM-1:0] req_wen;
    logic [31:0]   req_addr  [NM];
    logic [63:0]   req_wdata [NM];
    logic [7:0]    req_wstrb [NM];
    logic [7:0]    req_len   [NM];

    logic [NM*32-1:0] f_addr;
    logic [NM*64-1:0] f_wdata;
    logic [NM*8-1:0]  f_wstrb;
    logic [NM*8-1:0]  f_len;

    always_comb begin
        f_addr  = '0;
        f_wdata = '0;
        f_wstrb = '0;
        f_len   = '0;
        for (int i = 0; i < NM; i++) begin
            f_addr[i*32 +: 32]  = req_addr[i];
            f_wdata[i*64 +: 64] = req_wdata[i];
            f_wstrb[i*8 +: 8]   = req_wstrb[i];
            f_len[i*8 +: 8]     = req_len[i];
        end
    end

    logic        s_req_ready;
    logic        s_rsp_valid;
    logic [63:0] s_rsp_data;
    logic        s_rsp_last;

    logic [NM-1:0] o_req_ready [2];
    logic [NM-1:0] o_rsp_valid [2];
    logic [63:0]   o_rsp_data  [2];
    logic          o_rsp_last  [2];
    logic          o_s_vld     [2];
    logic [31:0]   o_s_addr    [2];
    logic          o_s_wen     [2];
    logic [63:0]   o_s_wdata   [2];
    logic [7:0]    o_s_wstrb   [2];
    logic [7:0]    o_s_len     [2];
    logic [1:0]    o_gid       [2];
    logic          o_busy      [2];
    logic          o_err       [2];

    // Instance 0 is round-robin, instance 1 is fixed priority.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        ysyx_22040632_rr_arbiter #(
            .NUM_M (NM),
            .RR_EN ((k == 0) ? 1 : 0)
        ) dut (
            .clk         (clk),
            .rrst_n      (rrst_n),
            .m_req_valid (req_valid),
            .m_req_ready (o_req_ready[k]),
            .m_req_addr  (f_addr),
            .m_req_wen   (req_wen),
            .m_req_wdata (f_wdata),
            .m_req_wstrb (f_wstrb),
            .m_req_len   (f_len),
            .m_rsp_valid (o_rsp_valid[k]),
            .m_rsp_data  (o_rsp_data[k]),
            .m_rsp_last  (o_rsp_last[k]),
            .s_req_valid (o_s_vld[k]),
            .s_req_ready (s_req_ready),
            .s_req_addr  (o_s_addr[k]),
            .s_req_wen   (o_s_wen[k]),
            .s_req_wdata (o_s_wdata[k]),
            .s_req_wstrb (o_s_wstrb[k]),
            .s_req_len   (o_s_len[k]),
            .s_rsp_valid (s_rsp_valid),
            .s_rsp_data  (s_rsp_data),
            .s_rsp_last  (s_rsp_last),
            .grant_id    (o_gid[k]),
            .busy        (o_busy[k]),
            .proto_err   (o_err[k])
        );
    end

    int n_run  = 0;
    int n_fail = 0;
    int tx     = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: wait for the request, accept it, deliver beats, confirm return to IDLE.
    task automatic do_txn(input int ea, input int eb, input int beats, input int last_at, input int exp_wait);
        int e [2];
        int n;
        logic [3:0]  oh;
        logic [63:0] d;
        e[0] = ea;
        e[1] = eb;
        n    = 0;
        tx++;
        tick();
        while (!o_s_vld[0] && n < 16) begin
            tick();
            n++;
        end
        check_eq($sformatf("req_wait t%0d", tx), 64'(n), 64'(exp_wait));
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("s_vld t%0d d%0d", tx, k), 64'(o_s_vld[k]), 64'd1);
            check_eq($sformatf("gid t%0d d%0d", tx, k), 64'(o_gid[k]), 64'(e[k]));
            check_eq($sformatf("addr t%0d d%0d", tx, k), 64'(o_s_addr[k]), 64'(req_addr[e[k]]));
            check_eq($sformatf("wen t%0d d%0d", tx, k), 64'(o_s_wen[k]), 64'(req_wen[e[k]]));
            check_eq($sformatf("len t%0d d%0d", tx, k), 64'(o_s_len[k]),
                     req_wen[e[k]] ? 64'd0 : 64'(req_len[e[k]]));
            if (req_wen[e[k]]) begin
                check_eq($sformatf("wdata t%0d d%0d", tx, k), o_s_wdata[k], req_wdata[e[k]]);
                check_eq($sformatf("wstrb t%0d d%0d", tx, k), 64'(o_s_wstrb[k]), 64'(req_wstrb[e[k]]));
            end
            check_eq($sformatf("rdy_pre t%0d d%0d", tx, k), 64'(o_req_ready[k]), 64'd0);
        end
        s_req_ready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            oh = 4'b0001 << e[k];
            check_eq($sformatf("rdy t%0d d%0d", tx, k), 64'(o_req_ready[k]), 64'(oh));
        end
        tick();
        s_req_ready = 1'b0;
        for (int b = 0; b < beats; b++) begin
            d = 64'hD00D_0000_0000_0000 | (64'(tx) << 16) | 64'(b);
            s_rsp_valid = 1'b1;
            s_rsp_data  = d;
            s_rsp_last  = (b == last_at);
            #1;
            for (int k = 0; k < 2; k++) begin
                oh = 4'b0001 << e[k];
                check_eq($sformatf("rsp_vld t%0d b%0d d%0d", tx, b, k), 64'(o_rsp_valid[k]), 64'(oh));
                check_eq($sformatf("rsp_dat t%0d b%0d d%0d", tx, b, k), o_rsp_data[k], d);
                check_eq($sformatf("rsp_lst t%0d b%0d d%0d", tx, b, k), 64'(o_rsp_last[k]), 64'(b == last_at));
            end
            tick();
        end
        s_rsp_valid = 1'b0;
        s_rsp_last  = 1'b0;
        s_rsp_data  = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("idle t%0d d%0d", tx, k), 64'(o_busy[k]), 64'd0);
            check_eq($sformatf("bubble t%0d d%0d", tx, k), 64'(o_s_vld[k]), 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s s_vld d%0d", tag, k), 64'(o_s_vld[k]), 64'd0);
            check_eq($sformatf("%s busy d%0d", tag, k), 64'(o_busy[k]), 64'd0);
            check_eq($sformatf("%s gid d%0d", tag, k), 64'(o_gid[k]), 64'd0);
            check_eq($sformatf("%s err d%0d", tag, k), 64'(o_err[k]), 64'd0);
            check_eq($sformatf("%s rdy d%0d", tag, k), 64'(o_req_ready[k]), 64'd0);
            check_eq($sformatf("%s rsp_vld d%0d", tag, k), 64'(o_rsp_valid[k]), 64'd0);
            check_eq($sformatf("%s rsp_dat d%0d", tag, k), o_rsp_data[k], 64'd0);
            check_eq($sformatf("%s rsp_lst d%0d", tag, k), 64'(o_rsp_last[k]), 64'd0);
            check_eq($sformatf("%s addr d%0d", tag, k), 64'(o_s_addr[k]), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rrst_n      = 1'b0;
        req_valid   = '0;
        req_wen     = '0;
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b1;
        s_rsp_data  = 64'hFFFF_0000_1234_5678;
        s_rsp_last  = 1'b1;
        for (int i = 0; i < NM; i++) begin
            req_addr[i]  = 32'h1000_0000 | (32'(i) << 8);
            req_wdata[i] = 64'h1111_0000_0000_0000 | 64'(i);
            req_wstrb[i] = 8'hFF;
            req_len[i]   = 8'd0;
        end
        tick();
        tick();
        check_all_zero("reset");
        s_rsp_valid = 1'b0;
        s_rsp_data  = '0;
        s_rsp_last  = 1'b0;
        rrst_n      = 1'b1;

        // Two 4-beat reads; RR serves 0 then 1, fixed priority serves 0 twice.
        req_len[0] = 8'd3;
        req_len[1] = 8'd3;
        req_valid  = 4'b0011;
        do_txn(0, 0, 4, 3, 0);
        do_txn(1, 0, 4, 3, 0);
        req_valid  = '0;
        req_len[0] = 8'd0;
        req_len[1] = 8'd0;
        for (int k = 0; k < 2; k++) check_eq($sformatf("err_reads d%0d", k), 64'(o_err[k]), 64'd0);

        // Write from master 2: len is ignored, one beat with last.
        req_wen[2]   = 1'b1;
        req_addr[2]  = 32'h8000_0010;
        req_wdata[2] = 64'h0000_0000_DEAD_BEEF;
        req_wstrb[2] = 8'h0F;
        req_len[2]   = 8'd5;
        req_valid    = 4'b0100;
        do_txn(2, 2, 1, 0, 0);
        req_valid    = '0;
        req_wen[2]   = 1'b0;
        req_len[2]   = 8'd0;
        for (int k = 0; k < 2; k++) check_eq($sformatf("err_write d%0d", k), 64'(o_err[k]), 64'd0);

        // Read len=1 but the slave ends it on the first beat.
        req_len[3] = 8'd1;
        req_valid  = 4'b1000;
        do_txn(3, 3, 1, 0, 0);
        req_valid  = '0;
        req_len[3] = 8'd0;
        for (int k = 0; k < 2; k++) check_eq($sformatf("err_short d%0d", k), 64'(o_err[k]), 64'd1);

        // All four continuous: RR pointer has wrapped to 0, so 0,1,2,3,0.
        req_valid = 4'b1111;
        do_txn(0, 0, 1, 0, 0);
        do_txn(1, 0, 1, 0, 0);
        do_txn(2, 0, 1, 0, 0);
        do_txn(3, 0, 1, 0, 0);
        do_txn(0, 0, 1, 0, 0);
        req_valid = '0;
        for (int k = 0; k < 2; k++) check_eq($sformatf("err_sticky d%0d", k), 64'(o_err[k]), 64'd1);

        // Masters 1 and 3 continuous: fixed priority keeps serving 1.
        req_valid = 4'b1010;
        do_txn(1, 1, 1, 0, 0);
        do_txn(3, 1, 1, 0, 0);
        do_txn(1, 1, 1, 0, 0);
        req_valid = '0;

        // Reset during beat 2 of a 4-beat burst from master 3.
        req_len[3] = 8'd3;
        req_valid  = 4'b1000;
        tick();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_burst s_vld d%0d", k), 64'(o_s_vld[k]), 64'd1);
            check_eq($sformatf("rst_burst gid d%0d", k), 64'(o_gid[k]), 64'd3);
        end
        s_req_ready = 1'b1;
        tick();
        s_req_ready = 1'b0;
        req_valid   = '0;
        s_rsp_valid = 1'b1;
        s_rsp_data  = 64'hBEA7_0000_0000_0001;
        s_rsp_last  = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check_eq($sformatf("rst_beat1 d%0d", k), 64'(o_rsp_valid[k]), 64'h8);
        tick();
        s_rsp_data = 64'hBEA7_0000_0000_0002;
        #1;
        rrst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        s_rsp_valid = 1'b0;
        s_rsp_data  = '0;
        req_len[3]  = 8'd0;
        tick();
        rrst_n = 1'b1;

        // Pointer restarts at 0: master 1 beats master 2.
        req_valid = 4'b0110;
        do_txn(1, 1, 1, 0, 0);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
